// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared defaults, word type and sizing helper for the transmit FIFO.
package tx_fifo_pkg;

    localparam int TX_DATA_WIDTH = 128;
    localparam int TX_ADDR_BITS  = 4;

    // Word type shared with the transmit serialiser.
    typedef logic [127:0] tx_word_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo_strobe.sv
// tx_fifo_strobe: request qualifier, rising-edge or level strobe of a request input.
//   clk    : clock
//   n_rst  : asynchronous active-low reset
//   req_i  : raw request
//   stb_o  : qualified strobe (edge of req_i when EDGE_MODE=1, req_i itself otherwise)
module tx_fifo_strobe #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic req_i,
    output logic stb_o
);

    logic prev_q;

    // prev_q resets low so a request held through reset release counts as one edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) prev_q <= 1'b0;
        else        prev_q <= req_i;
    end

    assign stb_o = EDGE_MODE ? (req_i & ~prev_q) : req_i;

endmodule

// File: rtl/tx_stream_fifo.sv
// tx_stream_fifo: parametrised show-ahead transmit FIFO with thresholds and sticky error flags.
//   clk, n_rst            : clock, asynchronous active-low reset
//   write_enable/_data    : write request and word
//   read_enable/read_data : pop request and head word (show-ahead)
//   err_clear             : synchronous clear of overflow/underflow
//   fifo_empty/fifo_full, almost_full/almost_empty, count : occupancy status
//   overflow/underflow    : sticky rejected-write / rejected-read flags
module tx_stream_fifo
    import tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = TX_DATA_WIDTH,
    parameter int ADDR_BITS     = TX_ADDR_BITS,
    parameter bit EDGE_MODE     = 1'b1,
    parameter int AFULL_THRESH  = (1 << ADDR_BITS) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  err_clear,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AF_C    = (ADDR_BITS + 1)'(AFULL_THRESH);
    localparam logic [ADDR_BITS:0]   AE_C    = (ADDR_BITS + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_BITS-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_stb, rd_stb, full, empty, wr_acc, rd_acc;

    tx_fifo_strobe #(.EDGE_MODE(EDGE_MODE)) u_wr_stb (
        .clk   (clk),
        .n_rst (n_rst),
        .req_i (write_enable),
        .stb_o (wr_stb)
    );

    tx_fifo_strobe #(.EDGE_MODE(EDGE_MODE)) u_rd_stb (
        .clk   (clk),
        .n_rst (n_rst),
        .req_i (read_enable),
        .stb_o (rd_stb)
    );

    always_comb begin
        full        = count_q == DEPTH_C;
        empty       = count_q == '0;
        // A write into a full FIFO still fits when a read frees the head slot in the same edge.
        wr_acc      = wr_stb & (~full | rd_stb);
        rd_acc      = rd_stb & ~empty;
        wptr_d      = wr_acc ? wptr_q + PTR_ONE : wptr_q;
        rptr_d      = rd_acc ? rptr_q + PTR_ONE : rptr_q;
        count_d     = (wr_acc & ~rd_acc) ? count_q + CNT_ONE :
                      (rd_acc & ~wr_acc) ? count_q - CNT_ONE : count_q;
        // A new error event takes priority over err_clear in the same cycle.
        overflow_d  = (wr_stb & full & ~rd_stb) | (overflow_q & ~err_clear);
        underflow_d = (rd_stb & empty) | (underflow_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= write_data;
    end

    assign read_data    = mem_q[rptr_q];
    assign count        = count_q;
    assign fifo_empty   = count_q == '0;
    assign fifo_full    = count_q == DEPTH_C;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
